// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: request/response bundle between the ID/EX buffer, hazard logic and the mul/div unit.
interface ex_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             in_start;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_Dato1;
  logic [WIDTH-1:0] in_Dato2;
  logic             in_flush;
  logic             ou_busy;
  logic             ou_stall;
  logic             ou_done;
  logic             ou_div0;
  logic [WIDTH-1:0] ou_HI;
  logic [WIDTH-1:0] ou_LO;
  modport master (
    output in_start, in_op, in_Dato1, in_Dato2, in_flush,
    input  ou_busy, ou_stall, ou_done, ou_div0, ou_HI, ou_LO
  );
  modport slave (
    input  in_start, in_op, in_Dato1, in_Dato2, in_flush,
    output ou_busy, ou_stall, ou_done, ou_div0, ou_HI, ou_LO
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU into HI/LO, stalling the pipeline while it runs.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  ex_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic is_div, neg_q, neg_r, dz_r, sgn, s1, s2, dz, go, ge;
  logic [WIDTH-1:0] a, mag1, mag2, hi, lo, hi_n, lo_n, hi_fix, lo_fix, sub;
  logic [2*WIDTH-1:0] acc, acc_nx, acc_n;
  logic [WIDTH:0] mul_sum, rem;
  assign sgn  = bus.in_op[0];
  assign s1   = sgn & bus.in_Dato1[WIDTH-1];
  assign s2   = sgn & bus.in_Dato2[WIDTH-1];
  assign mag1 = s1 ? -bus.in_Dato1 : bus.in_Dato1;
  assign mag2 = s2 ? -bus.in_Dato2 : bus.in_Dato2;
  assign dz   = bus.in_op[1] & ~|bus.in_Dato2;
  assign go   = (state == IDLE) & bus.in_start & ~bus.in_flush;
  assign bus.ou_busy  = state != IDLE;
  assign bus.ou_stall = bus.ou_busy | go;
  assign {hi, lo} = acc;
  // Multiply: shift-add with the multiplier consumed from the low half of acc.
  assign mul_sum = {1'b0, hi} + {1'b0, (acc[0] ? a : {WIDTH{1'b0}})};
  // Divide: restoring step on the partial remainder shifted left by one dividend bit.
  assign rem = {hi, lo[WIDTH-1]};
  assign ge  = rem >= {1'b0, a};
  assign sub = rem[WIDTH-1:0] - a;
  assign acc_nx = !is_div ? {mul_sum, lo[WIDTH-1:1]} :
                  ge      ? {sub, lo[WIDTH-2:0], 1'b1} :
                            {rem[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
  assign acc_n  = -acc;
  assign hi_n   = -hi;
  assign lo_n   = -lo;
  assign hi_fix = is_div ? (neg_r ? hi_n : hi) : (neg_q ? acc_n[2*WIDTH-1:WIDTH] : hi);
  assign lo_fix = neg_q ? (is_div ? lo_n : acc_n[WIDTH-1:0]) : lo;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = go ? (dz ? FIX : RUN) : IDLE;
    else if (bus.in_flush) state_nx = IDLE;
    else if (state == RUN) state_nx = (cnt == CW'(1)) ? FIX : RUN;
    else state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_r        <= 1'b0;
      a           <= '0;
      acc         <= '0;
      bus.ou_HI   <= '0;
      bus.ou_LO   <= '0;
      bus.ou_done <= 1'b0;
      bus.ou_div0 <= 1'b0;
    end else begin
      bus.ou_done <= 1'b0;
      bus.ou_div0 <= 1'b0;
      if (go) begin
        a      <= mag2;
        // A zero divisor preloads the final HI/LO so FIX just publishes them unsigned.
        acc    <= dz ? {bus.in_Dato1, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, mag1};
        is_div <= bus.in_op[1];
        neg_q  <= ~dz & (s1 ^ s2);
        neg_r  <= ~dz & s1;
        dz_r   <= dz;
        cnt    <= CW'(WIDTH);
      end else if (state == RUN && !bus.in_flush) begin
        acc <= acc_nx;
        cnt <= cnt - CW'(1);
      end else if (state == FIX && !bus.in_flush) begin
        bus.ou_HI   <= hi_fix;
        bus.ou_LO   <= lo_fix;
        bus.ou_done <= 1'b1;
        bus.ou_div0 <= dz_r;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized + directed scoreboard bench for ex_muldiv_unit against a 64-bit arithmetic model.
module tb_ex_muldiv_unit;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ex_muldiv_unit_if #(.WIDTH(W)) bus();
  ex_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int passed = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [63:0] p;
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.div0 = 1'b0;
    if (op == 2'd0) p = {32'b0, x} * {32'b0, y};
    else if (op == 2'd1) p = sx * sy;
    else if (y == 0) begin
      p = {x, 32'hFFFF_FFFF};
      e.div0 = 1'b1;
    end else if (op == 2'd2) p = {x % y, x / y};
    else p = {32'(sx % sy), 32'(sx / sy)};
    {e.hi, e.lo} = p;
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.ou_done) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        e = q.pop_front();
        check("HI", bus.ou_HI, e.hi);
        check("LO", bus.ou_LO, e.lo);
        check("div0", bus.ou_div0, e.div0);
      end
    end
  end

  // Called at a negedge; returns at a negedge with in_start low.
  task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                       input int flush_at = -1, input bit hold = 1'b0);
    exp_t e;
    int lat, want;
    e = model(op, x, y);
    want = (op[1] && y == 0) ? 1 : W + 1;
    bus.in_op = op;
    bus.in_Dato1 = x;
    bus.in_Dato2 = y;
    bus.in_start = 1'b1;
    #1 check("stall_on_start", bus.ou_stall, 1);
    @(posedge clk);
    if (flush_at < 0) q.push_back(e);
    #1;
    if (!hold) bus.in_start = 1'b0;
    bus.in_Dato1 = $urandom;
    bus.in_Dato2 = $urandom;
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.ou_done || lat > W + 5) break;
      if (lat == 0 || lat == want - 1) check("busy_stall_running", {bus.ou_busy, bus.ou_stall}, 2'b11);
      if (lat == flush_at) begin
        bus.in_flush = 1'b1;
        @(posedge clk);
        #1 bus.in_flush = 1'b0;
        bus.in_start = 1'b0;
        @(negedge clk);
        check("flush_busy", bus.ou_busy, 0);
        check("flush_hi_lo_kept", {bus.ou_HI, bus.ou_LO}, {last_hi, last_lo});
        return;
      end
      @(posedge clk);
      lat++;
    end
    check("latency", lat, want);
    check("busy_at_done", bus.ou_busy, 0);
    bus.in_start = 1'b0;
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] op;
    logic [31:0] x, y;
    int r;
    bus.in_start = 1'b0;
    bus.in_op = 2'd0;
    bus.in_Dato1 = '0;
    bus.in_Dato2 = '0;
    bus.in_flush = 1'b0;
    #2;
    check("reset_flags", {bus.ou_busy, bus.ou_stall, bus.ou_done, bus.ou_div0}, 0);
    check("reset_hi_lo", {bus.ou_HI, bus.ou_LO}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.in_start = 1'b1;
    bus.in_flush = 1'b1;
    #1 check("stall_flush_wins", bus.ou_stall, 0);
    @(posedge clk);
    #1 bus.in_start = 1'b0;
    bus.in_flush = 1'b0;
    @(negedge clk);
    check("flush_start_idle", bus.ou_busy, 0);
    check("idle_stall", bus.ou_stall, 0);
    issue(2'd0, 32'hFFFF_FFFF, 32'h2);
    issue(2'd1, -32'sd3, 32'd5);
    issue(2'd3, -32'sd7, 32'd2);
    issue(2'd2, 32'd100, 32'd7);
    issue(2'd2, 32'd5, 32'd0);
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'd3, -32'sd9, 32'd0);
    issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    repeat (3) @(negedge clk);
    issue(2'd1, 32'd1234, -32'sd56, -1, 1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      op = 2'($urandom_range(0, 3));
      x = $urandom;
      r = $urandom_range(0, 9);
      y = (r == 0) ? 32'd0 : (r < 4) ? 32'($urandom_range(1, 100)) :
          (r == 4) ? 32'hFFFF_FFFF : $urandom;
      if (r == 5) x = -32'($urandom_range(0, 1000));
      issue(op, x, y);
    end
    bus.in_op = 2'd0;
    bus.in_Dato1 = 32'd77;
    bus.in_Dato2 = 32'd3;
    bus.in_start = 1'b1;
    @(posedge clk);
    #1 bus.in_start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_flags", {bus.ou_busy, bus.ou_stall, bus.ou_done, bus.ou_div0}, 0);
    check("midrun_reset_hi_lo", {bus.ou_HI, bus.ou_LO}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_hi = '0;
    last_lo = '0;
    issue(2'd2, 32'hDEAD_BEEF, 32'd16);
    repeat (2) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
